xinlv_poll_ctrl: RTL and testbench

- Scheduler/controller for the heart-rate (xinlv) sensor UART link.
- Periodically issues a 2-byte request frame to the sensor via a UART TX byte handshake.
- Collects and validates the 3-byte response from the UART RX byte stream, then publishes the heart rate.
- Sits between the UART receive/transmit byte engines and the display/consumer logic; replaces free-running once-per-second latching.

---
 rtl/xinlv_pkg.sv | 24 ++
 rtl/xinlv_avg4.sv | 45 ++++
 rtl/xinlv_poll_ctrl.sv | 175 +++++++++++++++++
 tb/tb_xinlv_poll_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xinlv_pkg.sv
// Shared definitions for the heart-rate sensor poll controller: FSM states,
// protocol byte defaults, accepted heart-rate range and the frame checksum.
package xinlv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_HDR,
        S_TX_CMD,
        S_RX_HDR,
        S_RX_HR,
        S_RX_CK,
        S_CHECK
    } state_t;

    localparam logic [7:0] REQ_HDR_DEF = 8'hFF;
    localparam logic [7:0] REQ_CMD_DEF = 8'hA1;
    localparam logic [7:0] HR_MIN_DEF  = 8'd30;
    localparam logic [7:0] HR_MAX_DEF  = 8'd220;

    function automatic logic [7:0] ck_sum(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/xinlv_avg4.sv
// Four-sample moving average of accepted heart-rate samples. avg_next is the
// average that results once `sample` is pushed; unfilled slots mirror the first sample.
module xinlv_avg4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] sample,
    output logic [7:0] avg_next
);

    logic [7:0] hist_q [3];
    logic [7:0] hist_d [3];
    logic [7:0] eff    [3];
    logic [2:0] fill_q, fill_d;
    logic [9:0] sum;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        for (int unsigned i = 0; i < 3; i++) begin
            eff[i] = (fill_q == '0) ? sample : hist_q[i];
        end
        sum      = 10'(sample) + 10'(eff[0]) + 10'(eff[1]) + 10'(eff[2]);
        avg_next = sum[9:2];
        if (push) begin
            hist_d[0] = sample;
            hist_d[1] = eff[0];
            hist_d[2] = eff[1];
            if (fill_q != 3'd4) begin
                fill_d = fill_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '{default: '0};
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/xinlv_poll_ctrl.sv
// Periodic request/response scheduler for the heart-rate sensor UART link.
// Define XINLV_AVG_EN to publish a 4-sample moving average instead of the raw sample.
module xinlv_poll_ctrl
    import xinlv_pkg::*;
#(
    parameter int unsigned POLL_PERIOD_CYC = 50_000_000,
    parameter int unsigned TIMEOUT_CYC     = 5_000_000,
    parameter logic [7:0]  REQ_HDR         = REQ_HDR_DEF,
    parameter logic [7:0]  REQ_CMD         = REQ_CMD_DEF,
    parameter logic [7:0]  HR_MIN          = HR_MIN_DEF,
    parameter logic [7:0]  HR_MAX          = HR_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_int,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic [7:0] xinlv,
    output logic       xinlv_upd,
    output logic       link_ok,
    output logic [7:0] err_cnt
);

    state_t      state_q, state_d;
    logic [31:0] poll_cnt_q, poll_cnt_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        pending_q, pending_d;
    logic [7:0]  hr_q, hr_d;
    logic [7:0]  ck_q, ck_d;
    logic [7:0]  xinlv_q, xinlv_d;
    logic        upd_q, upd_d;
    logic        link_q, link_d;
    logic [7:0]  err_q, err_d;
    logic        tick, pass, timeout, fail;
    logic [7:0]  hr_pub;

`ifdef XINLV_AVG_EN
    logic [7:0] avg_next;

    xinlv_avg4 u_avg4 (
        .clk      (clk),
        .rst      (rst),
        .push     (state_q == S_CHECK && pass),
        .sample   (hr_q),
        .avg_next (avg_next)
    );

    assign hr_pub = avg_next;
`else
    assign hr_pub = hr_q;
`endif

    always_comb begin
        tick       = (poll_cnt_q == 32'(POLL_PERIOD_CYC - 1));
        poll_cnt_d = tick ? '0 : poll_cnt_q + 32'd1;
        timeout    = (to_cnt_q == 32'(TIMEOUT_CYC - 1));
        pass       = (ck_q == ck_sum(REQ_HDR, hr_q)) && (hr_q >= HR_MIN) && (hr_q <= HR_MAX);

        state_d   = state_q;
        pending_d = pending_q | tick;
        to_cnt_d  = to_cnt_q;
        hr_d      = hr_q;
        ck_d      = ck_q;
        xinlv_d   = xinlv_q;
        upd_d     = 1'b0;
        link_d    = link_q;
        err_d     = err_q;
        fail      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;

        if (state_q inside {S_RX_HDR, S_RX_HR, S_RX_CK}) begin
            to_cnt_d = to_cnt_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                // a tick landing on the consuming cycle re-arms pending
                if (pending_q) begin
                    pending_d = tick;
                    state_d   = S_TX_HDR;
                end
            end
            S_TX_HDR: begin
                tx_valid = 1'b1;
                tx_data  = REQ_HDR;
                if (tx_ready) state_d = S_TX_CMD;
            end
            S_TX_CMD: begin
                tx_valid = 1'b1;
                tx_data  = REQ_CMD;
                if (tx_ready) begin
                    state_d  = S_RX_HDR;
                    to_cnt_d = '0;
                end
            end
            S_RX_HDR: begin
                if (timeout) begin
                    fail    = 1'b1;
                    state_d = S_IDLE;
                end else if (rx_int && rx_data == REQ_HDR) begin
                    state_d = S_RX_HR;
                end
            end
            S_RX_HR: begin
                if (timeout) begin
                    fail    = 1'b1;
                    state_d = S_IDLE;
                end else if (rx_int) begin
                    hr_d    = rx_data;
                    state_d = S_RX_CK;
                end
            end
            S_RX_CK: begin
                if (timeout) begin
                    fail    = 1'b1;
                    state_d = S_IDLE;
                end else if (rx_int) begin
                    ck_d    = rx_data;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (pass) begin
                    xinlv_d = hr_pub;
                    upd_d   = 1'b1;
                    link_d  = 1'b1;
                end else begin
                    fail = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            link_d = 1'b0;
            if (err_q != '1) err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            poll_cnt_q <= '0;
            to_cnt_q   <= '0;
            pending_q  <= 1'b0;
            hr_q       <= '0;
            ck_q       <= '0;
            xinlv_q    <= '0;
            upd_q      <= 1'b0;
            link_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            to_cnt_q   <= to_cnt_d;
            pending_q  <= pending_d;
            hr_q       <= hr_d;
            ck_q       <= ck_d;
            xinlv_q    <= xinlv_d;
            upd_q      <= upd_d;
            link_q     <= link_d;
            err_q      <= err_d;
        end
    end

    assign xinlv     = xinlv_q;
    assign xinlv_upd = upd_q;
    assign link_ok   = link_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_xinlv_poll_ctrl.sv
// Directed bench for xinlv_poll_ctrl: a transaction-level model predicts the
// published outputs every cycle; literal checks pin key values and timings.
module tb_xinlv_poll_ctrl;

    localparam int unsigned P = 1000;
    localparam int unsigned T = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_int = 1'b0;
    logic [7:0] rx_data = '0;
    logic       tx_ready = 1'b1;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [7:0] xinlv;
    logic       xinlv_upd;
    logic       link_ok;
    logic [7:0] err_cnt;

    xinlv_poll_ctrl #(
        .POLL_PERIOD_CYC (P),
        .TIMEOUT_CYC     (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_int    (rx_int),
        .rx_data   (rx_data),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .xinlv     (xinlv),
        .xinlv_upd (xinlv_upd),
        .link_ok   (link_ok),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    typedef struct {
        int unsigned at;
        bit          pass;
        logic [7:0]  hr;
    } outcome_t;

    outcome_t    pend[$];
    logic [7:0]  hist[$];
    logic [7:0]  exp_xinlv = '0;
    logic [7:0]  exp_err   = '0;
    logic        exp_link  = 1'b0;
    int unsigned upd_at    = 32'hFFFF_FFFF;
    bit          cmp_on    = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit accepts(input logic [7:0] hr, input logic [7:0] ck);
        int unsigned want;
        want = (32'd255 + 32'(hr)) % 256;
        return (32'(ck) == want) && (hr >= 8'd30) && (hr <= 8'd220);
    endfunction

    function automatic void apply(input outcome_t o);
        int unsigned s;
        int          k;
        if (o.pass) begin
            hist.push_back(o.hr);
`ifdef XINLV_AVG_EN
            s = 0;
            for (int i = 0; i < 4; i++) begin
                k = int'(hist.size()) - 1 - i;
                s += (k >= 0) ? 32'(hist[k]) : 32'(hist[0]);
            end
            exp_xinlv = 8'(s / 4);
`else
            s = 0;
            k = 0;
            exp_xinlv = o.hr;
`endif
            exp_link = 1'b1;
            upd_at   = o.at;
        end else begin
            exp_link = 1'b0;
            if (exp_err != 8'd255) exp_err = exp_err + 8'd1;
        end
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            while (pend.size() > 0 && pend[0].at <= cyc) apply(pend.pop_front());
            check("xinlv",     32'(xinlv),     32'(exp_xinlv));
            check("link_ok",   32'(link_ok),   32'(exp_link));
            check("err_cnt",   32'(err_cnt),   32'(exp_err));
            check("xinlv_upd", 32'(xinlv_upd), 32'(cyc == upd_at));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int unsigned start);
        int unsigned w;
        w = 0;
        while (tx_valid !== 1'b1 && w < 3 * P) begin
            step();
            w++;
        end
        start = cyc;
        check("req_valid", 32'(tx_valid), 32'd1);
        check("req_hdr",   32'(tx_data),  32'hFF);
    endtask

    task automatic finish_req(output int unsigned xe);
        step();
        check("req_cmd_valid", 32'(tx_valid), 32'd1);
        check("req_cmd",       32'(tx_data),  32'hA1);
        step();
        check("req_done",      32'(tx_valid), 32'd0);
        xe = cyc;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        rx_int  = 1'b1;
        rx_data = b;
        step();
        rx_int  = 1'b0;
        step();
    endtask

    // Bytes are left-aligned in `bytes`; the frame starts at the first FF.
    task automatic respond(input int n, input logic [31:0] bytes);
        logic [7:0] b [4];
        int         hi;
        outcome_t   o;
        hi = -1;
        for (int i = 0; i < 4; i++) b[i] = bytes[31 - 8 * i -: 8];
        for (int i = n - 1; i >= 0; i--) if (b[i] == 8'hFF) hi = i;
        for (int i = 0; i < n; i++) begin
            if (hi >= 0 && i == hi + 2) begin
                o.at   = cyc + 2;
                o.hr   = b[hi + 1];
                o.pass = accepts(b[hi + 1], b[i]);
                pend.push_back(o);
            end
            drive_byte(b[i]);
        end
    endtask

    task automatic transact(input int n, input logic [31:0] bytes);
        int unsigned s;
        int unsigned xe;
        wait_req(s);
        finish_req(xe);
        respond(n, bytes);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s;
        int unsigned s2;
        int unsigned xe;
        int unsigned ns;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_valid),  32'd0);
        check("rst_tx_data",  32'(tx_data),   32'd0);
        check("rst_xinlv",    32'(xinlv),     32'd0);
        check("rst_upd",      32'(xinlv_upd), 32'd0);
        check("rst_link",     32'(link_ok),   32'd0);
        check("rst_err",      32'(err_cnt),   32'd0);
        cmp_on = 1'b1;
        rst    = 1'b0;

        // nominal
        wait_req(s);
        check("first_req_cycle", s, P + 1);
        finish_req(xe);
        respond(3, 32'hFF484700);
        check("nom_xinlv", 32'(xinlv),     32'd72);
        check("nom_upd",   32'(xinlv_upd), 32'd1);
        check("nom_link",  32'(link_ok),   32'd1);
        check("nom_err",   32'(err_cnt),   32'd0);

        // checksum error
        transact(3, 32'hFF480000);
        check("ck_xinlv", 32'(xinlv),     32'd72);
        check("ck_upd",   32'(xinlv_upd), 32'd0);
        check("ck_link",  32'(link_ok),   32'd0);
        check("ck_err",   32'(err_cnt),   32'd1);

        // range limits
        transact(3, 32'hFF141300);
        check("lo_link", 32'(link_ok), 32'd0);
        check("lo_err",  32'(err_cnt), 32'd2);
        transact(3, 32'hFFDCDB00);
        check("hi_link", 32'(link_ok), 32'd1);
        check("hi_err",  32'(err_cnt), 32'd2);
`ifndef XINLV_AVG_EN
        check("hi_xinlv", 32'(xinlv), 32'd220);
`endif

        // timeout with no response
        wait_req(s);
        finish_req(xe);
        begin
            outcome_t o;
            o.at = xe + T;
            o.pass = 1'b0;
            o.hr = '0;
            pend.push_back(o);
        end
        while (cyc < xe + T - 1) step();
        check("to_before_link", 32'(link_ok), 32'd1);
        step();
        check("to_link", 32'(link_ok), 32'd0);
        check("to_err",  32'(err_cnt), 32'd3);
        // bytes arriving while idle must be ignored
        drive_byte(8'hFF);
        drive_byte(8'h48);
        drive_byte(8'h47);
        check("idle_rx_link", 32'(link_ok), 32'd0);

        // resync past a stray leading byte
        transact(4, 32'h05FF4847);
        check("rs_link", 32'(link_ok), 32'd1);
        check("rs_err",  32'(err_cnt), 32'd3);
`ifndef XINLV_AVG_EN
        check("rs_xinlv", 32'(xinlv), 32'd72);
`endif

        // backpressure spanning two ticks
        tx_ready = 1'b0;
        wait_req(s);
        for (int i = 0; i < 2100; i++) begin
            step();
            check("bp_valid", 32'(tx_valid), 32'd1);
            check("bp_data",  32'(tx_data),  32'hFF);
        end
        tx_ready = 1'b1;
        finish_req(xe);
        respond(3, 32'hFF484700);
        s2 = cyc;
        wait_req(s);
        check("bp_extra_start", s, s2 + 1);
        finish_req(xe);
        respond(3, 32'hFF484700);
        ns = (cyc / P + 1) * P + 1;
        while (tx_valid !== 1'b1 && cyc < ns + 5) step();
        check("bp_next_start", cyc, ns);
        transact(3, 32'hFF484700);

        // reset in RX_HR
        wait_req(s);
        finish_req(xe);
        drive_byte(8'hFF);
        rst = 1'b1;
        step();
        pend.delete();
        hist.delete();
        exp_xinlv = '0;
        exp_err   = '0;
        exp_link  = 1'b0;
        upd_at    = 32'hFFFF_FFFF;
        check("mrst_tx_valid", 32'(tx_valid),  32'd0);
        check("mrst_tx_data",  32'(tx_data),   32'd0);
        check("mrst_xinlv",    32'(xinlv),     32'd0);
        check("mrst_upd",      32'(xinlv_upd), 32'd0);
        check("mrst_link",     32'(link_ok),   32'd0);
        check("mrst_err",      32'(err_cnt),   32'd0);
        rst = 1'b0;
        wait_req(s);
        check("mrst_req_cycle", s, P + 1);
        finish_req(xe);
        respond(3, 32'hFF3C3B00);
`ifdef XINLV_AVG_EN
        check("avg_1", 32'(xinlv), 32'd60);
        transact(3, 32'hFF504F00);
        check("avg_2", 32'(xinlv), 32'd65);
        transact(3, 32'hFF646300);
        check("avg_3", 32'(xinlv), 32'd75);
        transact(3, 32'hFF787700);
        check("avg_4", 32'(xinlv), 32'd90);
`else
        check("raw_1", 32'(xinlv), 32'd60);
        transact(3, 32'hFF504F00);
        check("raw_2", 32'(xinlv), 32'd80);
        transact(3, 32'hFF646300);
        check("raw_3", 32'(xinlv), 32'd100);
        transact(3, 32'hFF787700);
        check("raw_4", 32'(xinlv), 32'd120);
`endif
        step();
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
